ex_muldiv_sequencer: RTL and testbench

//   Sequences an iterative 32-bit multiply/divide unit alongside the EX-stage ALU for

---
 rtl/ex_muldiv_sequencer.sv | 158 +++++++++++++++
 tb/tb_ex_muldiv_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_sequencer.sv
// Iterative radix-2 multiply/divide sequencer for MULT/MULTU/DIV/DIVU, owning HI/LO.
// One shift-add or restoring shift-subtract step per cycle; stalls the pipeline while busy.
module ex_muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH:0]    wh_q, wh_d;
  logic [WIDTH-1:0]  wl_q, wl_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic              bz_q, bz_d;
  logic              div_zero_q, div_zero_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;

  logic              sa, sb;
  logic [WIDTH:0]    sum, sh, trial;
  logic [WIDTH:0]    wh_step;
  logic [WIDTH-1:0]  wl_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]  quo, rem;

  // Datapath step: wh holds the running high half / partial remainder, wl the
  // multiplier bits being consumed / dividend bits shifting out as quotient bits shift in.
  always_comb begin
    sum   = {1'b0, wh_q[WIDTH-1:0]} + {1'b0, (wl_q[0] ? b_q : {WIDTH{1'b0}})};
    sh    = {wh_q[WIDTH-1:0], wl_q[WIDTH-1]};
    trial = sh - {1'b0, b_q};
    if (op_q[1]) begin
      wh_step = trial[WIDTH] ? sh : trial;
      wl_step = {wl_q[WIDTH-2:0], ~trial[WIDTH]};
    end else begin
      wh_step = {1'b0, sum[WIDTH:1]};
      wl_step = {sum[0], wl_q[WIDTH-1:1]};
    end
    prod = {wh_step[WIDTH-1:0], wl_step};
    if (neg_q) prod = -prod;
    quo = wl_step;
    if (neg_q) quo = -quo;
    rem = wh_step[WIDTH-1:0];
    if (rneg_q) rem = -rem;
  end

  assign sa = ~op_i[0] & opa_i[WIDTH-1];
  assign sb = ~op_i[0] & opb_i[WIDTH-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    wh_d       = wh_q;
    wl_d       = wl_q;
    b_d        = b_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    bz_d       = bz_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && !flush_i) begin
          state_d    = StBusy;
          op_d       = op_i;
          wh_d       = '0;
          wl_d       = sa ? -opa_i : opa_i;
          b_d        = sb ? -opb_i : opb_i;
          neg_d      = sa ^ sb;
          rneg_d     = sa;
          bz_d       = (opb_i == '0);
          cnt_d      = CntW'(WIDTH - 1);
          div_zero_d = 1'b0;
        end
      end
      StBusy: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          wh_d  = wh_step;
          wl_d  = wl_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = StDone;
            if (op_q[1]) begin
              // Zero divisor: remainder path already reproduces the dividend.
              lo_d       = bz_q ? '1 : quo;
              hi_d       = rem;
              div_zero_d = bz_q;
            end else begin
              {hi_d, lo_d} = prod;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      wh_q       <= '0;
      wl_q       <= '0;
      b_q        <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      bz_q       <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      wh_q       <= wh_d;
      wl_q       <= wl_d;
      b_q        <= b_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      bz_q       <= bz_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign stall_o    = ((state_q == StIdle) && start_i && !flush_i) || (state_q == StBusy);
  assign busy_o     = (state_q == StBusy);
  assign done_o     = (state_q == StDone);
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed self-checking bench for ex_muldiv_sequencer with hand-computed results.
module tb_ex_muldiv_sequencer;

  logic        clk, rst, start, flush;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic        stall, busy, done, div_zero;
  logic [31:0] hi, lo;
  int          errors, checks, done_cnt;

  ex_muldiv_sequencer #(.WIDTH(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .opa_i      (opa),
    .opb_i      (opb),
    .flush_i    (flush),
    .stall_o    (stall),
    .busy_o     (busy),
    .done_o     (done),
    .div_zero_o (div_zero),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  // Issues one op and tracks it to DONE; returns the DONE cycle (-1 on timeout)
  // and the number of cycles where stall disagreed with the expected pattern.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int done_cyc, output int stall_bad);
    int cyc;
    stall_bad = 0;
    done_cyc  = -1;
    start = 1'b1; op = o; opa = a; opb = b;
    #1;
    if (!stall) stall_bad++;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      if (done) begin
        done_cyc = cyc;
        if (stall) stall_bad++;
        break;
      end
      if (!stall) stall_bad++;
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", div_zero); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int dc, sb;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, dc, sb);
    checks++; if (dc !== 33) begin errors++; $display("FAIL multu_done_cycle: got %0d want 33", dc); end
    checks++; if (sb !== 0) begin errors++; $display("FAIL multu_stall: got %0d bad cycles want 0", sb); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, dc, sb);
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_neg_lo: got %h want ffffffeb", lo); end
    run_op(2'b00, 32'h80000000, 32'd2, dc, sb);
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_min_hi: got %h want ffffffff", hi); end
    checks++; if (lo !== 32'h00000000) begin errors++; $display("FAIL mult_min_lo: got %h want 00000000", lo); end
  endtask

  task automatic test_div();
    int dc, sb;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, dc, sb);
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
    run_op(2'b11, 32'd100, 32'd7, dc, sb);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 00000002", hi); end
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, dc, sb);
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negb_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL div_negb_hi: got %h want 00000001", hi); end
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, dc, sb);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
  endtask

  task automatic test_div_zero();
    int dc, sb;
    run_op(2'b11, 32'h1234, 32'h0, dc, sb);
    checks++; if (dc !== 33) begin errors++; $display("FAIL dz_done_cycle: got %0d want 33", dc); end
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL dz_hi: got %h want 00001234", hi); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_lo: got %h want ffffffff", lo); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", div_zero); end
    run_op(2'b10, 32'hFFFFFFFB, 32'h0, dc, sb);
    checks++; if (hi !== 32'hFFFFFFFB) begin errors++; $display("FAIL dz_signed_hi: got %h want fffffffb", hi); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_signed_lo: got %h want ffffffff", lo); end
    start = 1'b1; op = 2'b01; opa = 32'd2; opb = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b want 0", div_zero); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL dz_next_lo: got %h want 00000006", lo); end
  endtask

  task automatic test_flush_reset();
    int base;
    start = 1'b1; op = 2'b01; opa = 32'd5; opb = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
    base  = done_cnt;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL flush_hi: got %h want 00000000", hi); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL flush_lo: got %h want 00000006", lo); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (done_cnt !== base) begin errors++; $display("FAIL flush_no_done: got %0d pulses want 0", done_cnt - base); end
    start = 1'b1; op = 2'b00; opa = 32'hFFFFFFFD; opb = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if ({busy, stall, done, div_zero} !== 4'b0) begin
      errors++; $display("FAIL rst_mid_flags: got %b want 0000", {busy, stall, done, div_zero});
    end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst_mid_hilo: got %h want 0", {hi, lo}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int base, cyc;
    base  = done_cnt;
    start = 1'b1; op = 2'b01; opa = 32'd2; opb = 32'd3;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_done_cycle: got %0d want 33", cyc); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done: got busy %b want 0", busy); end
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_flush_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_flush_start: got busy %b want 0", busy); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL b2b_pulses: got %0d want 1", done_cnt - base); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL b2b_lo: got %h want 00000006", lo); end
  endtask

  initial begin
    errors = 0; checks = 0; done_cnt = 0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_flush_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
